// File: rtl/mac_seq_pkg.sv
// Shared definitions for the time-multiplexed MAC sequencer.
//   - state_e        : sequencer FSM states
//   - *_DEF          : default DATA_W / NTAPS / OUT_W
//   - acc_width()    : accumulator width that holds a full NTAPS-term sum
//   - addr_width()   : coefficient index width (at least 1 bit)
// Optional build macro used by this slice: SATURATE_EN (clamp the result
// instead of wrapping, and add a sat_flag output).
package mac_seq_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int NTAPS_DEF  = 5;
    localparam int OUT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Product width plus enough guard bits for NTAPS additions.
    function automatic int acc_width(input int data_w, input int ntaps);
        return 2 * data_w + $clog2(ntaps);
    endfunction

    // A single-tap build still needs a 1-bit index port.
    function automatic int addr_width(input int ntaps);
        return (ntaps > 1) ? $clog2(ntaps) : 1;
    endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Bus bundle for mac_sequencer: coefficient config port, attribute input
// stream (valid/ready), result output stream (valid/ready) and status.
//   master modport : upstream / downstream / config side
//   slave modport  : the sequencer itself
// With SATURATE_EN defined the bundle also carries sat_flag.
interface mac_sequencer_if
    import mac_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NTAPS  = NTAPS_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int ADDR_W = addr_width(NTAPS)
);
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [DATA_W-1:0] cfg_data;
    logic              cfg_err;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              busy;
    logic [15:0]       sample_cnt;
`ifdef SATURATE_EN
    logic              sat_flag;

    modport master (
        output cfg_we, cfg_addr, cfg_data, in_valid, in_data, out_ready,
        input  cfg_err, in_ready, out_valid, out_data, busy, sample_cnt, sat_flag
    );
    modport slave (
        input  cfg_we, cfg_addr, cfg_data, in_valid, in_data, out_ready,
        output cfg_err, in_ready, out_valid, out_data, busy, sample_cnt, sat_flag
    );
`else
    modport master (
        output cfg_we, cfg_addr, cfg_data, in_valid, in_data, out_ready,
        input  cfg_err, in_ready, out_valid, out_data, busy, sample_cnt
    );
    modport slave (
        input  cfg_we, cfg_addr, cfg_data, in_valid, in_data, out_ready,
        output cfg_err, in_ready, out_valid, out_data, busy, sample_cnt
    );
`endif

endinterface

// File: rtl/mac_coef_bank.sv
// NTAPS x DATA_W coefficient register file.
//   clk, rst   : clock, asynchronous active-high reset (all entries -> 0)
//   we_i       : write strobe, already qualified by the sequencer
//   waddr_i    : entry to write (must be < NTAPS when we_i is high)
//   wdata_i    : value to write
//   raddr_i    : read index
//   rdata_o    : combinational read of entry raddr_i
module mac_coef_bank
    import mac_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NTAPS  = NTAPS_DEF,
    parameter int ADDR_W = addr_width(NTAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] coef_q [NTAPS];

    genvar gi;
    generate
        for (gi = 0; gi < NTAPS; gi++) begin : g_coef
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    coef_q[gi] <= '0;
                end else if (we_i && (waddr_i == ADDR_W'(gi))) begin
                    coef_q[gi] <= wdata_i;
                end
            end
        end
    endgenerate

    // The sequencer never drives an index >= NTAPS.
    assign rdata_o = coef_q[raddr_i];

endmodule

// File: rtl/mac_sequencer.sv
// Time-multiplexed multiply-accumulate sequencer: one shared DATA_W x DATA_W
// multiplier computes sum(attr[i]*coef[i]) over NTAPS attribute beats and
// presents the sum as an OUT_W-bit result word.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : mac_sequencer_if.slave
//          cfg_we/cfg_addr/cfg_data -> coefficient writes (IDLE only), cfg_err pulse
//          in_valid/in_ready/in_data -> attribute beats
//          out_valid/out_ready/out_data -> result words
//          busy, sample_cnt -> status
// Build option SATURATE_EN: result clamps to all-ones instead of wrapping,
// and sat_flag reports the clamp alongside out_data.
module mac_sequencer
    import mac_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NTAPS  = NTAPS_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    mac_sequencer_if.slave  bus
);

    localparam int ACC_W  = acc_width(DATA_W, NTAPS);
    localparam int ADDR_W = addr_width(NTAPS);
    localparam int PROD_W = 2 * DATA_W;

    state_e             state_q;
    logic [ADDR_W-1:0]  idx_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic               out_valid_q;
    logic [OUT_W-1:0]   out_data_q;
    logic [OUT_W-1:0]   result_d;
    logic               cfg_err_q;
    logic [15:0]        sample_cnt_q;
    logic               sat_q;
    logic               sat_d;

    logic [DATA_W-1:0]  coef_rd;
    logic [PROD_W-1:0]  prod;
    logic               beat;
    logic               last_beat;
    logic               cfg_ok;

    // Writes land only while idle and in range; everything else is flagged.
    assign cfg_ok = bus.cfg_we && (state_q == IDLE) && (32'(bus.cfg_addr) < NTAPS);

    mac_coef_bank #(
        .DATA_W (DATA_W),
        .NTAPS  (NTAPS),
        .ADDR_W (ADDR_W)
    ) u_coef_bank (
        .clk     (clk),
        .rst     (rst),
        .we_i    (cfg_ok),
        .waddr_i (bus.cfg_addr),
        .wdata_i (bus.cfg_data),
        .raddr_i (idx_q),
        .rdata_o (coef_rd)
    );

    assign bus.in_ready   = (state_q != DONE);
    assign beat           = bus.in_valid && (state_q != DONE);
    // idx is 0 in IDLE, so this also covers a single-tap build.
    assign last_beat      = (32'(idx_q) == NTAPS - 1);

    assign prod  = bus.in_data * coef_rd;
    // The first beat restarts the sum rather than adding to a stale one.
    assign acc_d = ((state_q == IDLE) ? '0 : acc_q) + ACC_W'(prod);

`ifdef SATURATE_EN
    // Zero-extend both sides so the compare works for any ACC_W/OUT_W ratio.
    assign sat_d    = {{OUT_W{1'b0}}, acc_d} > {{ACC_W{1'b0}}, {OUT_W{1'b1}}};
    assign result_d = sat_d ? {OUT_W{1'b1}} : OUT_W'(acc_d);
`else
    assign sat_d    = 1'b0;
    assign result_d = OUT_W'(acc_d);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            acc_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            cfg_err_q    <= 1'b0;
            sample_cnt_q <= '0;
            sat_q        <= 1'b0;
        end else begin
            cfg_err_q <= bus.cfg_we && !cfg_ok;
            case (state_q)
                IDLE, ACC: begin
                    if (beat) begin
                        acc_q <= acc_d;
                        if (last_beat) begin
                            state_q     <= DONE;
                            idx_q       <= '0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= result_d;
                            sat_q       <= sat_d;
                        end else begin
                            state_q <= ACC;
                            idx_q   <= idx_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q      <= IDLE;
                        idx_q        <= '0;
                        out_valid_q  <= 1'b0;
                        sample_cnt_q <= sample_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.cfg_err    = cfg_err_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.sample_cnt = sample_cnt_q;
`ifdef SATURATE_EN
    assign bus.sat_flag   = sat_q;
`else
    // No clamp in this build; the register stays at its reset value.
    logic unused_sat;
    assign unused_sat = sat_q;
`endif

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed self-checking bench for mac_sequencer (default 8-bit, 5 taps, 16-bit result).
module tb_mac_sequencer;
    import mac_seq_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    mac_sequencer_if bus_if ();

    mac_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic [2:0] addr, input logic [7:0] data, input logic exp_err);
        bus_if.cfg_we   = 1'b1;
        bus_if.cfg_addr = addr;
        bus_if.cfg_data = data;
        tick();
        bus_if.cfg_we = 1'b0;
        $display("[TB] cfg write addr=%0d data=%0d cfg_err=%0b", addr, data, bus_if.cfg_err);
        check("cfg_err", 32'(bus_if.cfg_err), 32'(exp_err));
    endtask

    task automatic load_coefs(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                              input logic [7:0] c3, input logic [7:0] c4);
        write_coef(3'd0, c0, 1'b0);
        write_coef(3'd1, c1, 1'b0);
        write_coef(3'd2, c2, 1'b0);
        write_coef(3'd3, c3, 1'b0);
        write_coef(3'd4, c4, 1'b0);
    endtask

    task automatic send_beat(input logic [7:0] d);
        int n;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = d;
        n = 0;
        while (!bus_if.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) check("beat_timeout", 32'(bus_if.in_ready), 32'd1);
        tick();
        bus_if.in_valid = 1'b0;
        $display("[TB] beat %0d", d);
    endtask

    task automatic send_sample(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                               input logic [7:0] a3, input logic [7:0] a4);
        send_beat(a0);
        send_beat(a1);
        send_beat(a2);
        send_beat(a3);
        send_beat(a4);
    endtask

    // Called right after the last beat: the result must already be valid.
    task automatic take_result(input string tag, input logic [15:0] exp, input logic [15:0] exp_cnt);
        $display("[TB] result %s out_valid=%0b out_data=%0d", tag, bus_if.out_valid, bus_if.out_data);
        check({tag, "_valid"}, 32'(bus_if.out_valid), 32'd1);
        check({tag, "_data"}, 32'(bus_if.out_data), 32'(exp));
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.out_ready = 1'b0;
        check({tag, "_cnt"}, 32'(bus_if.sample_cnt), 32'(exp_cnt));
        check({tag, "_idle"}, 32'({bus_if.out_valid, bus_if.busy}), 32'd0);
    endtask

    initial begin
        logic [15:0] held;
        logic [15:0] sat_exp;
        int          nres;
        int          last_c;

        n_tests = 0;
        n_fail  = 0;
        bus_if.cfg_we    = 1'b0;
        bus_if.cfg_addr  = '0;
        bus_if.cfg_data  = '0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = '0;
        bus_if.out_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_out_data", 32'(bus_if.out_data), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_cnt", 32'(bus_if.sample_cnt), 32'd0);
        check("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        check("rst_cfg_err", 32'(bus_if.cfg_err), 32'd0);

        // 1: 10*1+20*2+30*3+40*4+50*5 = 550
        load_coefs(8'd1, 8'd2, 8'd3, 8'd4, 8'd5);
        send_sample(8'd10, 8'd20, 8'd30, 8'd40, 8'd50);
        check("t1_in_ready_done", 32'(bus_if.in_ready), 32'd0);
        take_result("t1", 16'd550, 16'd1);

        // 2: 5*255*255 = 325125 = 0x4F605
        load_coefs(8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
        send_sample(8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
`ifdef SATURATE_EN
        sat_exp = 16'hFFFF;
        check("t2_sat_flag", 32'(bus_if.sat_flag), 32'd1);
`else
        sat_exp = 16'hF605;
`endif
        check("t2_data", 32'(bus_if.out_data), 32'(sat_exp));

        // 3: back-pressure in DONE with a pending upstream beat
        held = bus_if.out_data;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = 8'h33;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("t3_hold_data", 32'(bus_if.out_data), 32'(held));
            check("t3_hold_valid", 32'(bus_if.out_valid), 32'd1);
            check("t3_in_ready", 32'(bus_if.in_ready), 32'd0);
        end
        bus_if.in_valid = 1'b0;
        take_result("t2", sat_exp, 16'd2);

        // 4: dropped config writes mid-sample; result uses the old coefficients
        load_coefs(8'd1, 8'd2, 8'd3, 8'd4, 8'd5);
        send_beat(8'd1);
        write_coef(3'd0, 8'd99, 1'b1);
        tick();
        check("t4_err_pulse_end", 32'(bus_if.cfg_err), 32'd0);
        write_coef(3'd7, 8'd99, 1'b1);
        send_beat(8'd1);
        send_beat(8'd1);
        send_beat(8'd1);
        send_beat(8'd1);
        take_result("t4a", 16'd15, 16'd3);
        write_coef(3'd7, 8'd42, 1'b1);
        // Write coef[0]=7 on the same edge as the first beat: the beat sees coef[0]=1.
        bus_if.cfg_we   = 1'b1;
        bus_if.cfg_addr = 3'd0;
        bus_if.cfg_data = 8'd7;
        send_beat(8'd2);
        bus_if.cfg_we = 1'b0;
        check("t4_same_edge_err", 32'(bus_if.cfg_err), 32'd0);
        send_beat(8'd0);
        send_beat(8'd0);
        send_beat(8'd0);
        send_beat(8'd0);
        take_result("t4b", 16'd2, 16'd4);
        send_sample(8'd1, 8'd0, 8'd0, 8'd0, 8'd0);
        take_result("t4c", 16'd7, 16'd5);

        // 5: asynchronous reset mid-sample
        send_beat(8'd3);
        send_beat(8'd3);
        send_beat(8'd3);
        #2;
        rst = 1'b1;
        #1;
        check("t5_busy_async", 32'(bus_if.busy), 32'd0);
        check("t5_valid_async", 32'(bus_if.out_valid), 32'd0);
        check("t5_cnt_async", 32'(bus_if.sample_cnt), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        send_sample(8'd9, 8'd9, 8'd9, 8'd9, 8'd9);
        take_result("t5", 16'd0, 16'd1);

        // 6: streaming, one result every NTAPS+1 cycles
        load_coefs(8'd1, 8'd2, 8'd3, 8'd4, 8'd5);
        bus_if.in_data   = 8'd1;
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b1;
        nres   = 0;
        last_c = -1;
        for (int c = 1; c <= 36; c++) begin
            tick();
            if (bus_if.out_valid) begin
                $display("[TB] stream result %0d at cycle %0d data=%0d", nres, c, bus_if.out_data);
                check("t6_data", 32'(bus_if.out_data), 32'd15);
                check("t6_cnt", 32'(bus_if.sample_cnt), 32'(1 + nres));
                if (last_c >= 0) check("t6_gap", 32'(c - last_c), 32'd6);
                last_c = c;
                nres++;
            end
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        check("t6_results", 32'(nres), 32'd6);
        check("t6_final_cnt", 32'(bus_if.sample_cnt), 32'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
